angle_slot_gen: RTL and testbench

Upstream timing stage of the rotating display. Converts the raw IR index-mark input into a measured rotation period and a stream of angular slot strobes, one per display column position (ROTATIONAL_RES per revolution). It feeds the frame manager's angle input and reports lock status for the status LEDs.

---
 rtl/angle_slot_gen.sv | 159 +++++++++++++++
 tb/tb_angle_slot_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/angle_slot_gen.sv
// angle_slot_gen
//   Turns the raw IR index mark into a measured revolution period and a
//   stream of angular slot strobes (ROTATIONAL_RES per revolution).
//
// Ports
//   clk_in        system clock (only clock)
//   rst_in        synchronous, active-high reset
//   ir_tripped    raw IR sensor, asynchronous to clk_in
//   slot          current angular slot index
//   slot_strobe   one-cycle pulse on each slot entry, slot 0 included
//   period        last measured revolution length in clk_in cycles
//   period_valid  one-cycle pulse when period is updated
//   locked        slot stream is trustworthy
module angle_slot_gen #(
  parameter int ROTATIONAL_RES = 180,
  parameter int THETA_RES      = 27,
  parameter int MIN_GAP        = 1200
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              ir_tripped,
  output logic [$clog2(ROTATIONAL_RES)-1:0] slot,
  output logic                              slot_strobe,
  output logic [THETA_RES-1:0]              period,
  output logic                              period_valid,
  output logic                              locked
);
  localparam int SLOT_W = $clog2(ROTATIONAL_RES);
  localparam int GAP_W  = $clog2(MIN_GAP + 1);

  localparam logic [THETA_RES-1:0] CNT_MAX   = '1;
  localparam logic [THETA_RES-1:0] RES_CNT   = THETA_RES'(ROTATIONAL_RES);
  localparam logic [THETA_RES:0]   RES_ACC   = (THETA_RES+1)'(ROTATIONAL_RES);
  localparam logic [SLOT_W-1:0]    LAST_SLOT = SLOT_W'(ROTATIONAL_RES - 1);
  localparam logic [GAP_W-1:0]     GAP_MIN   = GAP_W'(MIN_GAP);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  logic                 s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [THETA_RES-1:0] cnt_q, cnt_d;
  logic                 have_prev_q, have_prev_d;
  logic [1:0]           state_q, state_d;
  logic [THETA_RES-1:0] period_q, period_d;
  logic                 period_valid_q, period_valid_d;
  logic [THETA_RES:0]   acc_q, acc_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic                 slot_strobe_q, slot_strobe_d;
  logic                 locked_q, locked_d;

  logic                 raw_edge, accept, timed_out, meas_ok;
  logic [THETA_RES:0]   acc_sum;

  always_comb begin
    s1_d = ir_tripped;
    s2_d = s1_q;
    s3_d = s2_q;

    raw_edge  = s2_q & ~s3_q;
    accept    = raw_edge & (gap_q >= GAP_MIN);
    timed_out = (cnt_q == CNT_MAX);
    // A measurement needs a reference edge that has not aged out.
    meas_ok   = have_prev_q & ~timed_out;
    // acc < P < 2^THETA_RES, so the sum always fits in THETA_RES+1 bits.
    acc_sum   = acc_q + RES_ACC;

    // Gap counter saturates at MIN_GAP so the lockout clears and stays clear.
    if (accept)               gap_d = GAP_W'(1);
    else if (gap_q < GAP_MIN) gap_d = gap_q + 1'b1;
    else                      gap_d = gap_q;

    if (accept)         cnt_d = THETA_RES'(1);
    else if (timed_out) cnt_d = cnt_q;
    else                cnt_d = cnt_q + 1'b1;

    if (accept)         have_prev_d = 1'b1;
    else if (timed_out) have_prev_d = 1'b0;
    else                have_prev_d = have_prev_q;

    period_d       = period_q;
    period_valid_d = 1'b0;
    if (accept && meas_ok) begin
      period_d       = cnt_q;
      period_valid_d = 1'b1;
    end

    // An accepted edge always leaves UNLOCKED; it only reaches LOCKED when it
    // closes a valid measurement long enough to hold all slots.
    state_d = state_q;
    if (accept)
      state_d = (state_q != ST_UNLOCKED && meas_ok && cnt_q >= RES_CNT) ? ST_LOCKED : ST_ARMED;
    else if (timed_out)
      state_d = ST_UNLOCKED;

    locked_d = (state_d == ST_LOCKED);

    // Bresenham slot stepping: add RES per cycle, step a slot each time the
    // accumulator crosses P. The last slot holds until the next index edge.
    slot_d        = '0;
    acc_d         = '0;
    slot_strobe_d = 1'b0;
    if (state_d == ST_LOCKED) begin
      if (accept) begin
        slot_strobe_d = 1'b1;
      end else if (acc_sum >= {1'b0, period_q}) begin
        acc_d  = acc_sum - {1'b0, period_q};
        slot_d = slot_q;
        if (slot_q < LAST_SLOT) begin
          slot_d        = slot_q + 1'b1;
          slot_strobe_d = 1'b1;
        end
      end else begin
        acc_d  = acc_sum;
        slot_d = slot_q;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      gap_q          <= GAP_MIN;
      cnt_q          <= '0;
      have_prev_q    <= 1'b0;
      state_q        <= ST_UNLOCKED;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      acc_q          <= '0;
      slot_q         <= '0;
      slot_strobe_q  <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      gap_q          <= gap_d;
      cnt_q          <= cnt_d;
      have_prev_q    <= have_prev_d;
      state_q        <= state_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      acc_q          <= acc_d;
      slot_q         <= slot_d;
      slot_strobe_q  <= slot_strobe_d;
      locked_q       <= locked_d;
    end
  end

  assign slot         = slot_q;
  assign slot_strobe  = slot_strobe_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_angle_slot_gen.sv
// tb_angle_slot_gen
//   Bench for angle_slot_gen at ROTATIONAL_RES=4, THETA_RES=8, MIN_GAP=3.
module tb_angle_slot_gen;
  localparam int R    = 4;
  localparam int TR   = 8;
  localparam int MG   = 3;
  localparam int CMAX = (1 << TR) - 1;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       ir_tripped;
  logic [1:0] slot;
  logic       slot_strobe;
  logic [7:0] period;
  logic       period_valid;
  logic       locked;

  angle_slot_gen #(.ROTATIONAL_RES(R), .THETA_RES(TR), .MIN_GAP(MG)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .ir_tripped(ir_tripped),
    .slot(slot), .slot_strobe(slot_strobe), .period(period),
    .period_valid(period_valid), .locked(locked)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: tracks the time of the last accepted index edge and
  // derives every output from elapsed cycles with plain arithmetic.
  int cyc = 0;
  bit h0, h1, h2;          // ir sampled 1, 2, 3 edges ago
  bit has_acc, lock_flag;
  int last_acc;
  int m_slot, m_period;
  bit m_strobe, m_pv, m_locked;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step(input bit ir_v, input bit rst_v);
    int d;
    bit raw, acc, valid;
    cyc++;
    if (rst_v) begin
      h0 = 0; h1 = 0; h2 = 0;
      has_acc = 0; lock_flag = 0;
      m_slot = 0; m_strobe = 0; m_period = 0; m_pv = 0; m_locked = 0;
      return;
    end
    raw   = h1 && !h2;
    d     = has_acc ? (cyc - last_acc) : (1 << 20);
    acc   = raw && (d >= MG);
    valid = has_acc && (d < CMAX);
    m_pv = 0; m_slot = 0; m_strobe = 0;
    if (acc) begin
      if (valid) begin
        m_period  = d;
        m_pv      = 1;
        lock_flag = (d >= R);
      end else begin
        lock_flag = 0;
      end
      has_acc  = 1;
      last_acc = cyc;
      m_locked = lock_flag;
      m_strobe = lock_flag;
    end else begin
      m_locked = has_acc && lock_flag && (d < CMAX);
      if (m_locked) begin
        // slot n is entered ceil(n*P/R) cycles after slot 0, i.e. when n*P <= d*R
        m_slot   = imin(d * R / m_period, R - 1);
        m_strobe = (m_slot != imin((d - 1) * R / m_period, R - 1));
      end
    end
    h2 = h1; h1 = h0; h0 = ir_v;
  endtask

  task automatic tick(input bit ir_v, input bit rst_v);
    logic [12:0] got, exp;
    ir_tripped = ir_v;
    rst_in     = rst_v;
    @(posedge clk_in);
    model_step(ir_v, rst_v);
    @(negedge clk_in);
    got = {slot, slot_strobe, period, period_valid, locked};
    exp = {2'(m_slot), m_strobe, 8'(m_period), m_pv, m_locked};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL model cyc=%0d got slot=%0d stb=%0b per=%0d pv=%0b lck=%0b want slot=%0d stb=%0b per=%0d pv=%0b lck=%0b",
               cyc, slot, slot_strobe, period, period_valid, locked,
               m_slot, m_strobe, m_period, m_pv, m_locked);
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b0, 1'b0);
  endtask

  task automatic pulse();
    tick(1'b1, 1'b0);
  endtask

  task automatic check(input string nm, input int e_slot, input bit e_stb,
                       input int e_per, input bit e_pv, input bit e_lck);
    n_tests++;
    if (slot !== 2'(e_slot) || slot_strobe !== e_stb || period !== 8'(e_per) ||
        period_valid !== e_pv || locked !== e_lck) begin
      n_fail++;
      $display("FAIL %s: got slot=%0d stb=%0b per=%0d pv=%0b lck=%0b want slot=%0d stb=%0b per=%0d pv=%0b lck=%0b",
               nm, slot, slot_strobe, period, period_valid, locked,
               e_slot, e_stb, e_per, e_pv, e_lck);
    end
  endtask

  task automatic check_zero(input string nm, input int bad);
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: got %0d bad cycles want 0", nm, bad);
    end
  endtask

  typedef struct {
    int gap;      // cycles since the previous pulse
    bit pv;
    int per;
    bit lck;
    int slt;
    bit stb;
  } vec_t;

  initial begin
    vec_t tbl[12];
    int   bad;
    int   w, sel, lo;

    tbl[0]  = '{0,   0, 0,   0, 0, 0};
    tbl[1]  = '{20,  1, 20,  1, 0, 1};
    tbl[2]  = '{9,   1, 9,   1, 0, 1};
    tbl[3]  = '{4,   1, 4,   1, 0, 1};
    tbl[4]  = '{3,   1, 3,   0, 0, 0};
    tbl[5]  = '{3,   1, 3,   0, 0, 0};
    tbl[6]  = '{50,  1, 50,  1, 0, 1};
    tbl[7]  = '{254, 1, 254, 1, 0, 1};
    tbl[8]  = '{255, 0, 254, 0, 0, 0};
    tbl[9]  = '{10,  1, 10,  1, 0, 1};
    tbl[10] = '{256, 0, 10,  0, 0, 0};
    tbl[11] = '{4,   1, 4,   1, 0, 1};

    // reset state
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("reset", 0, 0, 0, 0, 0);
    run(5);

    // lock acquisition, latency and slot timing at P=20
    pulse(); run(2);
    check("edge1", 0, 0, 0, 0, 0);
    run(17); pulse(); run(1);
    check("latency_early", 0, 0, 0, 0, 0);
    run(1);
    check("lock", 0, 1, 20, 1, 1);
    run(4); check("pre_s1", 0, 0, 20, 0, 1);
    run(1); check("s1", 1, 1, 20, 0, 1);
    run(5); check("s2", 2, 1, 20, 0, 1);
    run(5); check("s3", 3, 1, 20, 0, 1);

    // slowdown: next edge 30 cycles after the previous one
    bad = 0;
    for (int i = 16; i <= 29; i++) begin
      tick(i == 28, 1'b0);
      if (slot !== 2'd3 || slot_strobe !== 1'b0) bad++;
    end
    check_zero("slowdown_hold", bad);
    run(1);
    check("slowdown_edge", 0, 1, 30, 1, 1);

    // edge lands on the cycle slot 2 is due (P=30 -> advance at +15)
    run(7); check("c_s0", 0, 0, 30, 0, 1);
    run(1); check("c_s1", 1, 1, 30, 0, 1);
    run(4); pulse(); run(1);
    check("c_pre", 1, 0, 30, 0, 1);
    run(1);
    check("collide", 0, 1, 15, 1, 1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      run(1);
      if (slot_strobe !== 1'b0 || slot !== 2'd0) bad++;
    end
    check_zero("collide_quiet", bad);
    run(1); check("c_next", 1, 1, 15, 0, 1);

    // debounce: pulse 2 cycles after an accepted edge is ignored
    run(8); pulse(); tick(1'b0, 1'b0); pulse();
    check("deb_acc", 0, 1, 15, 1, 1);
    run(2);
    check("deb_ignore", 0, 0, 15, 0, 1);
    run(10); pulse(); run(2);
    check("deb_acc2", 0, 1, 15, 1, 1);
    // 3 cycles after is accepted: period 3 < R drops lock
    pulse(); run(2);
    check("deb_short", 0, 0, 3, 1, 0);

    // timeout
    run(17); pulse(); run(2);
    check("relock20", 0, 1, 20, 1, 1);
    run(254); check("pre_timeout", 3, 0, 20, 0, 1);
    run(1);   check("timeout", 0, 0, 20, 0, 0);
    pulse(); run(2);
    check("to_first", 0, 0, 20, 0, 0);
    run(17); pulse(); run(2);
    check("to_relock", 0, 1, 20, 1, 1);

    // reset mid-revolution
    run(11); check("pre_rst", 2, 0, 20, 0, 1);
    tick(1'b0, 1'b1);
    check("rst_mid", 0, 0, 0, 0, 0);
    run(3); pulse(); run(2);
    check("rst_edge1", 0, 0, 0, 0, 0);
    run(17); pulse(); run(2);
    check("rst_relock", 0, 1, 20, 1, 1);

    // table-driven pulse trains
    tick(1'b0, 1'b1);
    run(3);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) run(tbl[i].gap - 3);
      pulse(); run(2);
      check($sformatf("vec%0d", i), tbl[i].slt, tbl[i].stb, tbl[i].per, tbl[i].pv, tbl[i].lck);
    end

    // randomized pulse trains, checked every cycle by the model
    tick(1'b0, 1'b1);
    for (int b = 0; b < 150; b++) begin
      w   = $urandom_range(1, 3);
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        tick(1'b0, 1'b1);
      end else begin
        if (sel < 5)       lo = $urandom_range(1, 4);
        else if (sel < 18) lo = $urandom_range(5, 40);
        else               lo = $urandom_range(240, 270);
        repeat (w) tick(1'b1, 1'b0);
        run(lo);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
